ysyx_220053_mem_arbiter: RTL and testbench

- Arbitrates and sequences the single shared data-memory port between the instruction-fetch requester (IFU, read-only) and the load/store requester (LSU, read/write).
- Performs byte-lane alignment:
  - generates the store write mask and shifted write data from MemOp and addr[2:0];
  - extracts and sign/zero-extends load data.
- Sits between IFU/LSU and the DPI-backed memory wrapper. Memory latency is variable, with req/ack handshake.

---
 rtl/ysyx_220053_mem_arbiter_if.sv | 45 ++++
 rtl/ysyx_220053_mem_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_ysyx_220053_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_220053_mem_arbiter_if.sv
// Bus bundle between the IFU/LSU requesters, the arbiter and the memory wrapper.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface ysyx_220053_mem_arbiter_if;
   logic        ifu_valid;
   logic [63:0] ifu_addr;
   logic        ifu_ready;
   logic        ifu_rvalid;
   logic [31:0] ifu_rdata;

   logic        lsu_valid;
   logic        lsu_wen;
   logic [2:0]  lsu_memop;
   logic [63:0] lsu_addr;
   logic [63:0] lsu_wdata;
   logic        lsu_ready;
   logic        lsu_rvalid;
   logic [63:0] lsu_rdata;
   logic        lsu_err;

   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_ack;
   logic [63:0] mem_rdata;

   modport slave (
      input  ifu_valid, ifu_addr,
      output ifu_ready, ifu_rvalid, ifu_rdata,
      input  lsu_valid, lsu_wen, lsu_memop, lsu_addr, lsu_wdata,
      output lsu_ready, lsu_rvalid, lsu_rdata, lsu_err,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      input  mem_ack, mem_rdata
   );

   modport master (
      output ifu_valid, ifu_addr,
      input  ifu_ready, ifu_rvalid, ifu_rdata,
      output lsu_valid, lsu_wen, lsu_memop, lsu_addr, lsu_wdata,
      input  lsu_ready, lsu_rvalid, lsu_rdata, lsu_err,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/ysyx_220053_mem_arbiter.sv
// Shared data-memory port arbiter for IFU (read-only) and LSU (read/write).
// Round-robin grant, byte-lane alignment for stores, load extension, timeout.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access in flight; ready offered to the granted requester
// BUSY_IF | IFU fetch issued, mem_req held until ack or timeout
// BUSY_LS | LSU load/store issued, mem_req held until ack or timeout
module ysyx_220053_mem_arbiter #(
   parameter int unsigned TIMEOUT_CYC = 256,
   parameter int unsigned CNT_W       = 9
) (
   input logic                      clk,
   input logic                      rst_n,
   ysyx_220053_mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_LS = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

   state_t            state_q, state_d;
   logic              last_lsu_q, last_lsu_d;
   logic [2:0]        memop_q, memop_d;
   logic [2:0]        offset_q, offset_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [63:0]       mem_addr_q, mem_addr_d;
   logic [63:0]       mem_wdata_q, mem_wdata_d;
   logic [7:0]        mem_wmask_q, mem_wmask_d;
   logic              ifu_rvalid_q, ifu_rvalid_d;
   logic [31:0]       ifu_rdata_q, ifu_rdata_d;
   logic              lsu_rvalid_q, lsu_rvalid_d;
   logic [63:0]       lsu_rdata_q, lsu_rdata_d;
   logic              lsu_err_q, lsu_err_d;

   logic              grant_ifu, grant_lsu, idle;
   logic              ifu_bad, lsu_bad, lsu_misal;
   logic [2:0]        lsu_off;
   logic [7:0]        lsu_size_mask;
   logic [63:0]       rd_shift, load_ext;

   // Round-robin: on a tie the requester that was not granted last wins.
   always_comb begin
      grant_ifu = bus.ifu_valid & (~bus.lsu_valid | last_lsu_q);
      grant_lsu = bus.lsu_valid & (~bus.ifu_valid | ~last_lsu_q);
      idle      = rst_n & (state_q == IDLE);
   end

   assign bus.ifu_ready  = idle & grant_ifu;
   assign bus.lsu_ready  = idle & grant_lsu;
   assign bus.ifu_rvalid = ifu_rvalid_q;
   assign bus.ifu_rdata  = ifu_rdata_q;
   assign bus.lsu_rvalid = lsu_rvalid_q;
   assign bus.lsu_rdata  = lsu_rdata_q;
   assign bus.lsu_err    = lsu_err_q;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.mem_wmask  = mem_wmask_q;

   // Access size and alignment of the incoming LSU request; memop[1:0] selects size.
   always_comb begin
      lsu_off = bus.lsu_addr[2:0];
      unique case (bus.lsu_memop[1:0])
         2'b00:   begin lsu_size_mask = 8'h0F; lsu_misal = (lsu_off[1:0] != 2'b00); end
         2'b01:   begin lsu_size_mask = 8'h01; lsu_misal = 1'b0; end
         2'b10:   begin lsu_size_mask = 8'h03; lsu_misal = lsu_off[0]; end
         default: begin lsu_size_mask = 8'hFF; lsu_misal = (lsu_off != 3'b000); end
      endcase
      // 111 is only illegal for loads; stores look at the size bits alone.
      lsu_bad = lsu_misal | (~bus.lsu_wen & (bus.lsu_memop == 3'b111));
      ifu_bad = (bus.ifu_addr[1:0] != 2'b00);
   end

   // Load data: bring the addressed lane down to bit 0, then extend per memop.
   always_comb begin
      rd_shift = bus.mem_rdata >> {offset_q, 3'b000};
      unique case (memop_q)
         3'b000:  load_ext = {{32{rd_shift[31]}}, rd_shift[31:0]};
         3'b001:  load_ext = {{56{rd_shift[7]}},  rd_shift[7:0]};
         3'b010:  load_ext = {{48{rd_shift[15]}}, rd_shift[15:0]};
         3'b011:  load_ext = rd_shift;
         3'b100:  load_ext = {32'h0, rd_shift[31:0]};
         3'b101:  load_ext = {56'h0, rd_shift[7:0]};
         3'b110:  load_ext = {48'h0, rd_shift[15:0]};
         default: load_ext = 64'h0;
      endcase
   end

   // Next-state and registered-output computation for the sequencing FSM.
   always_comb begin
      state_d      = state_q;
      last_lsu_d   = last_lsu_q;
      memop_d      = memop_q;
      offset_d     = offset_q;
      cnt_d        = cnt_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wmask_d  = mem_wmask_q;
      ifu_rvalid_d = 1'b0;
      ifu_rdata_d  = ifu_rdata_q;
      lsu_rvalid_d = 1'b0;
      lsu_err_d    = 1'b0;
      lsu_rdata_d  = lsu_rdata_q;

      case (state_q)
         IDLE: begin
            if (grant_ifu) begin
               last_lsu_d = 1'b0;
               if (ifu_bad) begin
                  ifu_rvalid_d = 1'b1;
                  ifu_rdata_d  = 32'h0;
               end else begin
                  state_d     = BUSY_IF;
                  offset_d    = bus.ifu_addr[2:0];
                  cnt_d       = CNT_LOAD;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = {bus.ifu_addr[63:3], 3'b000};
                  mem_wdata_d = 64'h0;
                  mem_wmask_d = 8'h00;
               end
            end else if (grant_lsu) begin
               last_lsu_d = 1'b1;
               if (lsu_bad) begin
                  lsu_rvalid_d = 1'b1;
                  lsu_err_d    = 1'b1;
                  lsu_rdata_d  = 64'h0;
               end else begin
                  state_d     = BUSY_LS;
                  memop_d     = bus.lsu_memop;
                  offset_d    = lsu_off;
                  cnt_d       = CNT_LOAD;
                  mem_req_d   = 1'b1;
                  mem_we_d    = bus.lsu_wen;
                  mem_addr_d  = {bus.lsu_addr[63:3], 3'b000};
                  mem_wdata_d = bus.lsu_wen ? (bus.lsu_wdata << {lsu_off, 3'b000}) : 64'h0;
                  mem_wmask_d = bus.lsu_wen ? (lsu_size_mask << lsu_off) : 8'h00;
               end
            end
         end
         BUSY_IF: begin
            if (bus.mem_ack) begin
               state_d      = IDLE;
               mem_req_d    = 1'b0;
               ifu_rvalid_d = 1'b1;
               ifu_rdata_d  = rd_shift[31:0];
            end else if (cnt_q == '0) begin
               state_d      = IDLE;
               mem_req_d    = 1'b0;
               ifu_rvalid_d = 1'b1;
               ifu_rdata_d  = 32'h0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         BUSY_LS: begin
            if (bus.mem_ack) begin
               state_d      = IDLE;
               mem_req_d    = 1'b0;
               lsu_rvalid_d = 1'b1;
               lsu_rdata_d  = mem_we_q ? 64'h0 : load_ext;
            end else if (cnt_q == '0) begin
               state_d      = IDLE;
               mem_req_d    = 1'b0;
               lsu_rvalid_d = 1'b1;
               lsu_err_d    = 1'b1;
               lsu_rdata_d  = 64'h0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers; synchronous reset makes IFU win the first tie.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_lsu_q   <= 1'b1;
         memop_q      <= 3'b000;
         offset_q     <= 3'b000;
         cnt_q        <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 64'h0;
         mem_wdata_q  <= 64'h0;
         mem_wmask_q  <= 8'h00;
         ifu_rvalid_q <= 1'b0;
         ifu_rdata_q  <= 32'h0;
         lsu_rvalid_q <= 1'b0;
         lsu_rdata_q  <= 64'h0;
         lsu_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_lsu_q   <= last_lsu_d;
         memop_q      <= memop_d;
         offset_q     <= offset_d;
         cnt_q        <= cnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wmask_q  <= mem_wmask_d;
         ifu_rvalid_q <= ifu_rvalid_d;
         ifu_rdata_q  <= ifu_rdata_d;
         lsu_rvalid_q <= lsu_rvalid_d;
         lsu_rdata_q  <= lsu_rdata_d;
         lsu_err_q    <= lsu_err_d;
      end
   end

endmodule

// File: tb/tb_ysyx_220053_mem_arbiter.sv
// Directed bench for the memory arbiter: fetch, loads, stores, misalignment,
// round-robin back-to-back grants, timeout and reset during a busy access.
module tb_ysyx_220053_mem_arbiter;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   ysyx_220053_mem_arbiter_if bus ();

   ysyx_220053_mem_arbiter #(.TIMEOUT_CYC(8), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic        we;
      logic [2:0]  op;
      logic [63:0] addr;
      logic [63:0] wd;
      logic        err;
      logic [63:0] rdata;
      logic [7:0]  mask;
      logic [63:0] wdata;
   } vec_t;

   vec_t vecs [0:7];

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   task automatic clear_inputs();
      bus.ifu_valid = 1'b0; bus.ifu_addr  = 64'h0;
      bus.lsu_valid = 1'b0; bus.lsu_wen   = 1'b0; bus.lsu_memop = 3'b000;
      bus.lsu_addr  = 64'h0; bus.lsu_wdata = 64'h0;
      bus.mem_ack   = 1'b0; bus.mem_rdata = 64'h0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Runs one LSU request, acking in the first mem_req cycle if one is issued.
   task automatic lsu_access(input logic we, input logic [2:0] op, input logic [63:0] addr,
                             input logic [63:0] wd, input logic [63:0] rd,
                             output logic o_ready, output logic o_req, output logic [63:0] o_addr,
                             output logic o_we, output logic [63:0] o_wdata, output logic [7:0] o_wmask,
                             output logic o_rvalid, output logic o_err, output logic [63:0] o_rdata);
      @(negedge clk);
      bus.lsu_valid = 1'b1; bus.lsu_wen = we; bus.lsu_memop = op;
      bus.lsu_addr = addr; bus.lsu_wdata = wd;
      #1 o_ready = bus.lsu_ready;
      @(negedge clk);
      bus.lsu_valid = 1'b0;
      o_req = bus.mem_req; o_addr = bus.mem_addr; o_we = bus.mem_we;
      o_wdata = bus.mem_wdata; o_wmask = bus.mem_wmask;
      o_rvalid = bus.lsu_rvalid; o_err = bus.lsu_err; o_rdata = bus.lsu_rdata;
      if (o_req) begin
         bus.mem_ack = 1'b1; bus.mem_rdata = rd;
         @(negedge clk);
         bus.mem_ack = 1'b0;
         o_rvalid = bus.lsu_rvalid; o_err = bus.lsu_err; o_rdata = bus.lsu_rdata;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); else passed++;
      checks++; if (bus.ifu_rvalid !== 1'b0 || bus.lsu_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b%b expected 00", bus.ifu_rvalid, bus.lsu_rvalid); else passed++;
      checks++; if (bus.lsu_err !== 1'b0 || bus.lsu_rdata !== 64'h0 || bus.ifu_rdata !== 32'h0) $display("FAIL reset_data: got err=%b lsu=%h ifu=%h expected zeros", bus.lsu_err, bus.lsu_rdata, bus.ifu_rdata); else passed++;
      checks++; if (bus.ifu_ready !== 1'b0 || bus.lsu_ready !== 1'b0) $display("FAIL reset_ready: got %b%b expected 00", bus.ifu_ready, bus.lsu_ready); else passed++;
   endtask

   task automatic test_ifu_fetch();
      @(negedge clk);
      bus.ifu_valid = 1'b1; bus.ifu_addr = 64'h8000_0004;
      #1;
      checks++; if (bus.ifu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) $display("FAIL fetch_ready: got %b%b expected 10", bus.ifu_ready, bus.lsu_ready); else passed++;
      @(negedge clk);
      bus.ifu_valid = 1'b0;
      checks++; if (bus.mem_req !== 1'b1) $display("FAIL fetch_req: got %b expected 1", bus.mem_req); else passed++;
      checks++; if (bus.mem_addr !== 64'h8000_0000) $display("FAIL fetch_addr: got %h expected 0000000080000000", bus.mem_addr); else passed++;
      checks++; if (bus.mem_we !== 1'b0) $display("FAIL fetch_we: got %b expected 0", bus.mem_we); else passed++;
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b1) $display("FAIL fetch_req_held: got %b expected 1", bus.mem_req); else passed++;
      bus.mem_ack = 1'b1; bus.mem_rdata = 64'h1234_5678_0000_0013;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      checks++; if (bus.ifu_rvalid !== 1'b1) $display("FAIL fetch_rvalid: got %b expected 1", bus.ifu_rvalid); else passed++;
      checks++; if (bus.ifu_rdata !== 32'h1234_5678) $display("FAIL fetch_rdata: got %h expected 12345678", bus.ifu_rdata); else passed++;
      checks++; if (bus.mem_req !== 1'b0) $display("FAIL fetch_req_drop: got %b expected 0", bus.mem_req); else passed++;
      @(negedge clk);
      checks++; if (bus.ifu_rvalid !== 1'b0) $display("FAIL fetch_pulse: got %b expected 0", bus.ifu_rvalid); else passed++;
   endtask

   task automatic test_lsu_load();
      logic rdy, req, we, rv, err;
      logic [63:0] a, wdat, rdat;
      logic [7:0] msk;
      vecs[0] = '{1'b0, 3'b001, 64'h8000_0003, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0};
      vecs[1] = '{1'b0, 3'b101, 64'h8000_0003, 64'h0, 1'b0, 64'h0000_0000_0000_0080, 8'h00, 64'h0};
      vecs[2] = '{1'b0, 3'b010, 64'h8000_0002, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_8066, 8'h00, 64'h0};
      vecs[3] = '{1'b0, 3'b110, 64'h8000_0002, 64'h0, 1'b0, 64'h0000_0000_0000_8066, 8'h00, 64'h0};
      vecs[4] = '{1'b0, 3'b000, 64'h8000_0000, 64'h0, 1'b0, 64'hFFFF_FFFF_8066_7788, 8'h00, 64'h0};
      vecs[5] = '{1'b0, 3'b100, 64'h8000_0004, 64'h0, 1'b0, 64'h0000_0000_1122_3344, 8'h00, 64'h0};
      vecs[6] = '{1'b0, 3'b011, 64'h8000_0008, 64'h0, 1'b0, 64'h1122_3344_8066_7788, 8'h00, 64'h0};
      vecs[7] = '{1'b0, 3'b001, 64'h8000_0007, 64'h0, 1'b0, 64'h0000_0000_0000_0011, 8'h00, 64'h0};
      for (int i = 0; i < 8; i++) begin
         lsu_access(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wd, 64'h1122_3344_8066_7788,
                    rdy, req, a, we, wdat, msk, rv, err, rdat);
         checks++; if (rdy !== 1'b1 || req !== 1'b1) $display("FAIL load%0d_issue: got ready=%b req=%b expected 1 1", i, rdy, req); else passed++;
         checks++; if (a !== (vecs[i].addr & ~64'h7) || we !== 1'b0) $display("FAIL load%0d_addr: got %h we=%b expected %h we=0", i, a, we, vecs[i].addr & ~64'h7); else passed++;
         checks++; if (rv !== 1'b1 || err !== 1'b0 || rdat !== vecs[i].rdata) $display("FAIL load%0d_data: got rv=%b err=%b %h expected 1 0 %h", i, rv, err, rdat, vecs[i].rdata); else passed++;
      end
   endtask

   task automatic test_store();
      logic rdy, req, we, rv, err;
      logic [63:0] a, wdat, rdat;
      logic [7:0] msk;
      vecs[0] = '{1'b1, 3'b010, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 1'b0, 64'h0, 8'hC0, 64'hBEEF_0000_0000_0000};
      vecs[1] = '{1'b1, 3'b110, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 1'b0, 64'h0, 8'hC0, 64'hBEEF_0000_0000_0000};
      vecs[2] = '{1'b1, 3'b101, 64'h8000_0005, 64'h0000_0000_0000_00AB, 1'b0, 64'h0, 8'h20, 64'h0000_AB00_0000_0000};
      vecs[3] = '{1'b1, 3'b000, 64'h8000_0004, 64'h0000_0000_DEAD_BEEF, 1'b0, 64'h0, 8'hF0, 64'hDEAD_BEEF_0000_0000};
      vecs[4] = '{1'b1, 3'b111, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0, 8'hFF, 64'h0123_4567_89AB_CDEF};
      for (int i = 0; i < 5; i++) begin
         lsu_access(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wd, 64'hFFFF_FFFF_FFFF_FFFF,
                    rdy, req, a, we, wdat, msk, rv, err, rdat);
         checks++; if (rdy !== 1'b1 || req !== 1'b1 || we !== 1'b1) $display("FAIL store%0d_issue: got ready=%b req=%b we=%b expected 1 1 1", i, rdy, req, we); else passed++;
         checks++; if (msk !== vecs[i].mask) $display("FAIL store%0d_wmask: got %h expected %h", i, msk, vecs[i].mask); else passed++;
         checks++; if (wdat !== vecs[i].wdata || a !== (vecs[i].addr & ~64'h7)) $display("FAIL store%0d_wdata: got %h @%h expected %h @%h", i, wdat, a, vecs[i].wdata, vecs[i].addr & ~64'h7); else passed++;
         checks++; if (rv !== 1'b1 || err !== 1'b0 || rdat !== 64'h0) $display("FAIL store%0d_done: got rv=%b err=%b %h expected 1 0 0", i, rv, err, rdat); else passed++;
      end
   endtask

   task automatic test_misaligned();
      logic rdy, req, we, rv, err;
      logic [63:0] a, wdat, rdat;
      logic [7:0] msk;
      vecs[0] = '{1'b0, 3'b011, 64'h8000_0004, 64'h0, 1'b1, 64'h0, 8'h00, 64'h0};
      vecs[1] = '{1'b0, 3'b000, 64'h8000_0002, 64'h0, 1'b1, 64'h0, 8'h00, 64'h0};
      vecs[2] = '{1'b0, 3'b110, 64'h8000_0001, 64'h0, 1'b1, 64'h0, 8'h00, 64'h0};
      vecs[3] = '{1'b1, 3'b011, 64'h8000_0003, 64'h55, 1'b1, 64'h0, 8'h00, 64'h0};
      vecs[4] = '{1'b0, 3'b111, 64'h8000_0000, 64'h0, 1'b1, 64'h0, 8'h00, 64'h0};
      for (int i = 0; i < 5; i++) begin
         lsu_access(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wd, 64'h7777_7777_7777_7777,
                    rdy, req, a, we, wdat, msk, rv, err, rdat);
         checks++; if (rdy !== 1'b1 || req !== 1'b0) $display("FAIL misal%0d_noreq: got ready=%b req=%b expected 1 0", i, rdy, req); else passed++;
         checks++; if (rv !== 1'b1 || err !== 1'b1 || rdat !== 64'h0) $display("FAIL misal%0d_err: got rv=%b err=%b %h expected 1 1 0", i, rv, err, rdat); else passed++;
      end
      @(negedge clk);
      checks++; if (bus.lsu_rvalid !== 1'b0 || bus.lsu_err !== 1'b0) $display("FAIL misal_pulse: got %b%b expected 00", bus.lsu_rvalid, bus.lsu_err); else passed++;
      bus.ifu_valid = 1'b1; bus.ifu_addr = 64'h8000_0002;
      #1;
      checks++; if (bus.ifu_ready !== 1'b1) $display("FAIL ifu_misal_ready: got %b expected 1", bus.ifu_ready); else passed++;
      @(negedge clk);
      bus.ifu_valid = 1'b0;
      checks++; if (bus.mem_req !== 1'b0 || bus.ifu_rvalid !== 1'b1 || bus.ifu_rdata !== 32'h0) $display("FAIL ifu_misal: got req=%b rv=%b %h expected 0 1 0", bus.mem_req, bus.ifu_rvalid, bus.ifu_rdata); else passed++;
   endtask

   task automatic test_back_to_back();
      logic        exp_ifu;
      logic [63:0] rd;
      do_reset();
      @(negedge clk);
      bus.ifu_valid = 1'b1; bus.ifu_addr = 64'h8000_0100;
      bus.lsu_valid = 1'b1; bus.lsu_wen = 1'b0; bus.lsu_memop = 3'b011; bus.lsu_addr = 64'h8000_0208;
      for (int i = 0; i < 4; i++) begin
         exp_ifu = ((i % 2) == 0);
         rd = {32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)};
         #1;
         checks++; if (bus.ifu_ready !== exp_ifu || bus.lsu_ready !== !exp_ifu) $display("FAIL rr%0d_grant: got ifu=%b lsu=%b expected ifu=%b lsu=%b", i, bus.ifu_ready, bus.lsu_ready, exp_ifu, !exp_ifu); else passed++;
         @(negedge clk);
         checks++; if (bus.ifu_ready === 1'b1 && bus.lsu_ready === 1'b1) $display("FAIL rr%0d_both_ready: got 11 expected not both", i); else passed++;
         checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== (exp_ifu ? 64'h8000_0100 : 64'h8000_0208)) $display("FAIL rr%0d_req: got req=%b %h expected 1 %h", i, bus.mem_req, bus.mem_addr, exp_ifu ? 64'h8000_0100 : 64'h8000_0208); else passed++;
         bus.mem_ack = 1'b1; bus.mem_rdata = rd;
         @(negedge clk);
         bus.mem_ack = 1'b0;
         if (exp_ifu) begin
            checks++; if (bus.ifu_rvalid !== 1'b1 || bus.lsu_rvalid !== 1'b0 || bus.ifu_rdata !== rd[31:0]) $display("FAIL rr%0d_ifu_resp: got rv=%b%b %h expected 10 %h", i, bus.ifu_rvalid, bus.lsu_rvalid, bus.ifu_rdata, rd[31:0]); else passed++;
         end else begin
            checks++; if (bus.lsu_rvalid !== 1'b1 || bus.ifu_rvalid !== 1'b0 || bus.lsu_rdata !== rd) $display("FAIL rr%0d_lsu_resp: got rv=%b%b %h expected 01 %h", i, bus.ifu_rvalid, bus.lsu_rvalid, bus.lsu_rdata, rd); else passed++;
         end
      end
      #1;
      checks++; if (bus.ifu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) $display("FAIL rr_fifth_grant: got %b%b expected 10", bus.ifu_ready, bus.lsu_ready); else passed++;
      bus.ifu_valid = 1'b0; bus.lsu_valid = 1'b0;
   endtask

   task automatic test_timeout();
      int n;
      @(negedge clk);
      bus.lsu_valid = 1'b1; bus.lsu_wen = 1'b0; bus.lsu_memop = 3'b011; bus.lsu_addr = 64'h8000_0010;
      @(negedge clk);
      bus.lsu_valid = 1'b0;
      n = 0;
      while (bus.mem_req === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      checks++; if (n != 8) $display("FAIL lsu_timeout_len: got %0d expected 8", n); else passed++;
      checks++; if (bus.lsu_rvalid !== 1'b1 || bus.lsu_err !== 1'b1 || bus.lsu_rdata !== 64'h0) $display("FAIL lsu_timeout_resp: got rv=%b err=%b %h expected 1 1 0", bus.lsu_rvalid, bus.lsu_err, bus.lsu_rdata); else passed++;
      bus.ifu_valid = 1'b1; bus.ifu_addr = 64'h8000_0020;
      @(negedge clk);
      bus.ifu_valid = 1'b0;
      n = 0;
      while (bus.mem_req === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      checks++; if (n != 8) $display("FAIL ifu_timeout_len: got %0d expected 8", n); else passed++;
      checks++; if (bus.ifu_rvalid !== 1'b1 || bus.ifu_rdata !== 32'h0 || bus.lsu_err !== 1'b0) $display("FAIL ifu_timeout_resp: got rv=%b %h err=%b expected 1 0 0", bus.ifu_rvalid, bus.ifu_rdata, bus.lsu_err); else passed++;
   endtask

   task automatic test_reset_mid_busy();
      @(negedge clk);
      bus.lsu_valid = 1'b1; bus.lsu_wen = 1'b0; bus.lsu_memop = 3'b011; bus.lsu_addr = 64'h8000_0030;
      @(negedge clk);
      bus.lsu_valid = 1'b0;
      checks++; if (bus.mem_req !== 1'b1) $display("FAIL midrst_busy: got %b expected 1", bus.mem_req); else passed++;
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b0) $display("FAIL midrst_req_drop: got %b expected 0", bus.mem_req); else passed++;
      rst_n = 1'b1;
      bus.mem_ack = 1'b1; bus.mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      checks++; if (bus.lsu_rvalid !== 1'b0 || bus.ifu_rvalid !== 1'b0 || bus.mem_req !== 1'b0) $display("FAIL stray_ack: got rv=%b%b req=%b expected 00 0", bus.ifu_rvalid, bus.lsu_rvalid, bus.mem_req); else passed++;
      bus.ifu_valid = 1'b1; bus.ifu_addr = 64'h8000_0040;
      bus.lsu_valid = 1'b1; bus.lsu_addr = 64'h8000_0048;
      #1;
      checks++; if (bus.ifu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) $display("FAIL midrst_tie: got %b%b expected 10", bus.ifu_ready, bus.lsu_ready); else passed++;
      bus.ifu_valid = 1'b0; bus.lsu_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b0) $display("FAIL midrst_idle: got %b expected 0", bus.mem_req); else passed++;
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_ifu_fetch();
      test_lsu_load();
      test_store();
      test_misaligned();
      test_back_to_back();
      test_timeout();
      test_reset_mid_busy();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
